intersections_core: RTL and testbench

INTERSECTIONS_CORE -- requirements
Module: intersections

---
 rtl/intersections_core.sv | 153 +++++++++++++++
 tb/tb_intersections_core.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/intersections_core.sv
// Intersection points of two circles, scaled by 2*D2, via an iterative integer sqrt.
// Latency 2N+7 edges from accepted start to done; start is ignored while busy.
module intersections_core #(
    parameter int N = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3*N:0]      g_input,
    input  logic [3*N:0]      e_input,
    output logic [14*N+33:0]  o,
    output logic              busy,
    output logic              done,
    output logic              no_int
);

    localparam int WA = 2*N + 4;    // A and squares of deltas
    localparam int WS = 2*N + 4;    // square-root result
    localparam int WD = 4*N + 8;    // discriminant / radicand, even width
    localparam int WR = WS + 3;     // sqrt partial remainder
    localparam int WY = 3*N + 7;    // result arithmetic width
    localparam int WO = 4*N + 10;   // x field width
    localparam int WC = $clog2(WS);

    typedef enum logic [2:0] {IDLE, PREP, DISC, SQRT, OUT} state_t;

    state_t state, state_nx;

    logic signed [N-1:0]   xb, yb, xc, yc;
    logic [N:0]            rb, rc;
    logic signed [N:0]     dx, dy;
    logic [2*N+1:0]        d2;
    logic signed [WA-1:0]  a;
    logic [WD-1:0]         rad;
    logic [WR-1:0]         rem;
    logic [WS-1:0]         root;
    logic [WC-1:0]         cnt;
    logic                  neg;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = PREP;
            PREP:    state_nx = DISC;
            DISC:    state_nx = SQRT;
            SQRT:    if (cnt == WC'(WS-1)) state_nx = OUT;
            OUT:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Deltas, D2 and A; modular arithmetic is exact because every true value fits.
    logic signed [N:0] dx_c, dy_c;
    logic [WA-1:0]     dx_sq, dy_sq, d2_c, a_c;

    assign dx_c  = (N+1)'(xc) - (N+1)'(xb);
    assign dy_c  = (N+1)'(yc) - (N+1)'(yb);
    assign dx_sq = WA'(dx_c) * WA'(dx_c);
    assign dy_sq = WA'(dy_c) * WA'(dy_c);
    assign d2_c  = dx_sq + dy_sq;
    assign a_c   = WA'(rb) * WA'(rb) - WA'(rc) * WA'(rc) + d2_c;

    logic [WD-1:0] a_w, disc_c;

    assign a_w    = WD'(a);
    assign disc_c = ((WD'(rb) * WD'(rb) * WD'(d2)) << 2) - (a_w * a_w);

    // One restoring sqrt step: bring down two radicand bits, try subtracting 4*root+1.
    logic [WR-1:0] rem_sh, trial;
    logic          ge;

    assign rem_sh = (rem << 2) | WR'(rad[WD-1 -: 2]);
    assign trial  = {1'b0, root, 2'b01};
    assign ge     = (rem_sh >= trial);

    logic signed [WY-1:0] d2_y, xb_y, yb_y, a_y, dx_y, dy_y, s_y;
    logic signed [WY-1:0] base_x, base_y, x1_f, y1_f, x2_f, y2_f;

    assign d2_y   = WY'(d2);
    assign xb_y   = WY'(xb);
    assign yb_y   = WY'(yb);
    assign a_y    = WY'(a);
    assign dx_y   = WY'(dx);
    assign dy_y   = WY'(dy);
    assign s_y    = WY'(root);
    assign base_x = ((d2_y * xb_y) <<< 1) + a_y * dx_y;
    assign base_y = ((d2_y * yb_y) <<< 1) + a_y * dy_y;
    assign x1_f   = base_x - dy_y * s_y;
    assign y1_f   = base_y + dx_y * s_y;
    assign x2_f   = base_x + dy_y * s_y;
    assign y2_f   = base_y - dx_y * s_y;

    always_ff @(posedge clk) begin
        if (rst) begin
            xb <= '0; yb <= '0; rb <= '0;
            xc <= '0; yc <= '0; rc <= '0;
            dx <= '0; dy <= '0; d2 <= '0; a <= '0;
            rad <= '0; rem <= '0; root <= '0; cnt <= '0; neg <= 1'b0;
            o <= '0; done <= 1'b0; no_int <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    xb <= g_input[3*N:2*N+1];
                    yb <= g_input[2*N:N+1];
                    rb <= g_input[N:0];
                    xc <= e_input[3*N:2*N+1];
                    yc <= e_input[2*N:N+1];
                    rc <= e_input[N:0];
                end
                PREP: begin
                    dx <= dx_c;
                    dy <= dy_c;
                    d2 <= d2_c[2*N+1:0];
                    a  <= a_c;
                end
                DISC: begin
                    // A negative discriminant collapses S to zero.
                    neg  <= disc_c[WD-1];
                    rad  <= disc_c[WD-1] ? '0 : disc_c;
                    rem  <= '0;
                    root <= '0;
                    cnt  <= '0;
                end
                SQRT: begin
                    rem  <= ge ? (rem_sh - trial) : rem_sh;
                    root <= {root[WS-2:0], ge};
                    rad  <= rad << 2;
                    cnt  <= cnt + 1'b1;
                end
                OUT: begin
                    done <= 1'b1;
                    if (d2 == '0) begin
                        o      <= '0;
                        no_int <= 1'b1;
                    end else begin
                        o      <= {WO'(x1_f), y1_f, WO'(x2_f), y2_f};
                        no_int <= neg;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_intersections_core.sv
// Directed bench for intersections_core at N=8 with hand-computed circle intersections.
module tb_intersections_core;

    localparam int N   = 8;
    localparam int LAT = 2*N + 7;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [3*N:0]        g_input;
    logic [3*N:0]        e_input;
    logic [14*N+33:0]    o;
    logic                busy;
    logic                done;
    logic                no_int;

    int checks = 0;
    int errors = 0;

    logic signed [41:0] x1, x2;
    logic signed [30:0] y1, y2;

    assign x1 = o[145:104];
    assign y1 = o[103:73];
    assign x2 = o[72:31];
    assign y2 = o[30:0];

    always #5 clk = ~clk;

    intersections_core #(.N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .g_input (g_input),
        .e_input (e_input),
        .o       (o),
        .busy    (busy),
        .done    (done),
        .no_int  (no_int)
    );

    function automatic logic [3*N:0] pack(input int x, input int y, input int r);
        return {x[7:0], y[7:0], r[8:0]};
    endfunction

    task automatic launch(input logic [3*N:0] g, input logic [3*N:0] e);
        @(negedge clk);
        g_input = g;
        e_input = e;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; g_input = '0; e_input = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (o !== '0)      begin errors++; $display("FAIL reset_o got %0h want 0", o); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (no_int !== 1'b0) begin errors++; $display("FAIL reset_no_int got %b want 0", no_int); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat;
        launch(pack(0, 0, 5), pack(6, 0, 5));
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", busy); end
        wait_done(lat);
        checks++; if (lat !== LAT)     begin errors++; $display("FAIL basic_latency got %0d want %0d", lat, LAT); end
        checks++; if (no_int !== 1'b0) begin errors++; $display("FAIL basic_no_int got %b want 0", no_int); end
        checks++; if (x1 !== 42'sd216)  begin errors++; $display("FAIL basic_x1 got %0d want 216", x1); end
        checks++; if (y1 !== 31'sd288)  begin errors++; $display("FAIL basic_y1 got %0d want 288", y1); end
        checks++; if (x2 !== 42'sd216)  begin errors++; $display("FAIL basic_x2 got %0d want 216", x2); end
        checks++; if (y2 !== -31'sd288) begin errors++; $display("FAIL basic_y2 got %0d want -288", y2); end
        @(posedge clk);
        #1;
        checks++; if (done !== 1'b0)   begin errors++; $display("FAIL basic_done_pulse got %b want 0", done); end
        checks++; if (x1 !== 42'sd216) begin errors++; $display("FAIL basic_hold_x1 got %0d want 216", x1); end
    endtask

    task automatic test_general();
        int lat;
        launch(pack(-32, 108, 215), pack(-16, -111, 236));
        wait_done(lat);
        checks++; if (lat !== LAT)     begin errors++; $display("FAIL general_latency got %0d want %0d", lat, LAT); end
        checks++; if (no_int !== 1'b0) begin errors++; $display("FAIL general_no_int got %b want 0", no_int); end
        checks++; if (x1 !== 42'sd16390824)  begin errors++; $display("FAIL general_x1 got %0d want 16390824", x1); end
        checks++; if (y1 !== 31'sd3307162)   begin errors++; $display("FAIL general_y1 got %0d want 3307162", y1); end
        checks++; if (x2 !== -42'sd21322728) begin errors++; $display("FAIL general_x2 got %0d want -21322728", x2); end
        checks++; if (y2 !== 31'sd551834)    begin errors++; $display("FAIL general_y2 got %0d want 551834", y2); end
    endtask

    task automatic test_no_int();
        int lat;
        launch(pack(0, 0, 1), pack(100, 0, 1));
        wait_done(lat);
        checks++; if (lat !== LAT)     begin errors++; $display("FAIL noint_latency got %0d want %0d", lat, LAT); end
        checks++; if (no_int !== 1'b1) begin errors++; $display("FAIL noint_flag got %b want 1", no_int); end
        checks++; if (x1 !== 42'sd1000000) begin errors++; $display("FAIL noint_x1 got %0d want 1000000", x1); end
        checks++; if (y1 !== 31'sd0)       begin errors++; $display("FAIL noint_y1 got %0d want 0", y1); end
        checks++; if (x2 !== 42'sd1000000) begin errors++; $display("FAIL noint_x2 got %0d want 1000000", x2); end
        checks++; if (y2 !== 31'sd0)       begin errors++; $display("FAIL noint_y2 got %0d want 0", y2); end
    endtask

    task automatic test_concentric();
        int lat;
        launch(pack(5, 5, 3), pack(5, 5, 4));
        wait_done(lat);
        checks++; if (lat !== LAT)     begin errors++; $display("FAIL concentric_latency got %0d want %0d", lat, LAT); end
        checks++; if (no_int !== 1'b1) begin errors++; $display("FAIL concentric_no_int got %b want 1", no_int); end
        checks++; if (o !== '0)        begin errors++; $display("FAIL concentric_o got %0h want 0", o); end
    endtask

    task automatic test_back_to_back();
        int lat;
        launch(pack(0, 0, 5), pack(6, 0, 5));
        wait_done(lat);
        checks++; if (lat !== LAT)      begin errors++; $display("FAIL b2b_first_latency got %0d want %0d", lat, LAT); end
        checks++; if (y2 !== -31'sd288) begin errors++; $display("FAIL b2b_first_y2 got %0d want -288", y2); end
        launch(pack(0, 0, 1), pack(100, 0, 1));
        wait_done(lat);
        checks++; if (lat !== LAT)         begin errors++; $display("FAIL b2b_second_latency got %0d want %0d", lat, LAT); end
        checks++; if (x1 !== 42'sd1000000) begin errors++; $display("FAIL b2b_second_x1 got %0d want 1000000", x1); end
        checks++; if (no_int !== 1'b1)     begin errors++; $display("FAIL b2b_second_no_int got %b want 1", no_int); end
    endtask

    task automatic test_abort();
        int lat;
        int dones;
        launch(pack(-32, 108, 215), pack(-16, -111, 236));
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        checks++; if (o !== '0)      begin errors++; $display("FAIL abort_o got %0h want 0", o); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got %b want 0", done); end
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        checks++; if (dones !== 0) begin errors++; $display("FAIL abort_no_done got %0d pulses want 0", dones); end
        launch(pack(0, 0, 5), pack(6, 0, 5));
        wait_done(lat);
        checks++; if (lat !== LAT)     begin errors++; $display("FAIL abort_restart_latency got %0d want %0d", lat, LAT); end
        checks++; if (x1 !== 42'sd216) begin errors++; $display("FAIL abort_restart_x1 got %0d want 216", x1); end
    endtask

    task automatic test_ignore_start();
        int dones;
        logic signed [41:0] x1_seen;
        logic signed [30:0] y1_seen, y2_seen;
        x1_seen = '0; y1_seen = '0; y2_seen = '0;
        launch(pack(0, 0, 5), pack(6, 0, 5));
        repeat (3) @(posedge clk);
        @(negedge clk);
        g_input = pack(-32, 108, 215);
        e_input = pack(-16, -111, 236);
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                if (dones == 0) begin
                    x1_seen = x1; y1_seen = y1; y2_seen = y2;
                end
                dones++;
            end
        end
        checks++; if (dones !== 1)           begin errors++; $display("FAIL ignore_done_count got %0d want 1", dones); end
        checks++; if (x1_seen !== 42'sd216)  begin errors++; $display("FAIL ignore_x1 got %0d want 216", x1_seen); end
        checks++; if (y1_seen !== 31'sd288)  begin errors++; $display("FAIL ignore_y1 got %0d want 288", y1_seen); end
        checks++; if (y2_seen !== -31'sd288) begin errors++; $display("FAIL ignore_y2 got %0d want -288", y2_seen); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_general();
        test_no_int();
        test_concentric();
        test_back_to_back();
        test_abort();
        test_ignore_start();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
